sw_debounce: RTL and testbench



---
 rtl/sw_debounce.sv | 62 ++++++
 tb/tb_sw_debounce.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: synchronise and debounce slide switches ahead of the switch PIO.
//   clk        in  1      system clock
//   reset      in  1      synchronous active-high reset
//   sw_raw     in  WIDTH  asynchronous raw switch levels
//   sw_clean   out WIDTH  debounced levels
//   sw_changed out WIDTH  one-cycle strobe in the first cycle showing a new sw_clean bit
module sw_debounce #(
    parameter int               WIDTH        = 10,
    parameter int               SYNC_STAGES  = 2,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 20,
    parameter logic [WIDTH-1:0] INIT         = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_changed
);
    localparam int PW = $clog2(TICK_DIV);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick;
    logic [7:0]       cnt_q [WIDTH];
    logic [7:0]       cnt_d [WIDTH];
    logic [WIDTH-1:0] clean_q, clean_d, changed_q, sw_sync, done;

    assign sw_sync = sync_q[SYNC_STAGES-1];
    assign tick    = presc_q == PW'(TICK_DIV - 1);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // A channel is a candidate exactly while sw_sync differs from sw_clean,
    // so the tick count is cleared on reversion and counts ticks otherwise.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        assign done[i]  = (sw_sync[i] != clean_q[i]) && tick && cnt_q[i] == 8'(STABLE_TICKS - 1);
        assign cnt_d[i] = (sw_sync[i] == clean_q[i] || done[i]) ? 8'd0 :
                          tick ? cnt_q[i] + 8'd1 : cnt_q[i];
    end

    assign clean_d    = clean_q ^ done;
    assign sw_clean   = clean_q;
    assign sw_changed = changed_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Loading INIT into the synchroniser avoids a false candidate at release.
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= INIT;
            for (int k = 0; k < WIDTH; k++) cnt_q[k] <= 8'd0;
            presc_q   <= '0;
            clean_q   <= INIT;
            changed_q <= '0;
        end else begin
            sync_q[0] <= sw_raw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            for (int k = 0; k < WIDTH; k++) cnt_q[k] <= cnt_d[k];
            presc_q   <= presc_d;
            clean_q   <= clean_d;
            changed_q <= done;
        end
    end
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: scoreboarded bench for sw_debounce plus directed latency/pulse checks.
module tb_sw_debounce;
    localparam int W = 10, TD = 4, ST = 3, SS = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_clean, sw_changed;

    always #5 clk = ~clk;

    sw_debounce #(
        .WIDTH(W), .SYNC_STAGES(SS), .TICK_DIV(TD), .STABLE_TICKS(ST), .INIT({W{1'b0}})
    ) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_clean(sw_clean), .sw_changed(sw_changed)
    );

    int n_chk = 0, n_err = 0, cyc = 0, lat;
    int m_phase = 0;
    int m_ticks [W];
    int pulses [W];
    logic [W-1:0] m_s0, m_s1, m_clean, m_chg;
    logic [2*W-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_pulses();
        for (int i = 0; i < W; i++) pulses[i] = 0;
    endtask

    // One clock: drive inputs, advance the reference model, queue its
    // expectation, then pop it and compare once the DUT outputs settle.
    task automatic step(input logic r, input logic [W-1:0] v);
        logic tk;
        logic [2*W-1:0] e;
        reset  = r;
        sw_raw = v;
        @(posedge clk);
        tk = (m_phase == TD - 1);
        if (r) begin
            m_s0 = '0; m_s1 = '0; m_clean = '0; m_chg = '0; m_phase = 0;
            for (int i = 0; i < W; i++) m_ticks[i] = 0;
        end else begin
            m_chg = '0;
            for (int i = 0; i < W; i++) begin
                if (m_s1[i] != m_clean[i]) begin
                    if (tk) begin
                        m_ticks[i]++;
                        if (m_ticks[i] == ST) begin
                            m_clean[i] = ~m_clean[i];
                            m_chg[i]   = 1'b1;
                            m_ticks[i] = 0;
                        end
                    end
                end else m_ticks[i] = 0;
            end
            m_s1 = m_s0;
            m_s0 = v;
            m_phase = (m_phase + 1) % TD;
        end
        exp_q.push_back({m_clean, m_chg});
        #1;
        cyc++;
        e = exp_q.pop_front();
        chk("sb", 32'({sw_clean, sw_changed}), 32'(e));
        for (int i = 0; i < W; i++) if (sw_changed[i]) pulses[i]++;
    endtask

    // Lat counts cycles from the cycle in which v is first driven; -1 on timeout.
    task automatic wait_chg(input int b, input logic [W-1:0] v, input int lim, output int l);
        l = -1;
        for (int k = 0; k < lim && l < 0; k++) begin
            step(1'b0, v);
            if (sw_changed[b]) l = k + 1;
        end
        chk("wait_timeout", 32'(l >= 0), 1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) step(1'b1, '0);
        chk("rst_clean", 32'(sw_clean), 0);
        chk("rst_chg", 32'(sw_changed), 0);
        for (int k = 0; k < 5; k++) step(1'b0, '0);

        clr_pulses();
        wait_chg(0, 10'h001, 20, lat);
        chk("rise_lat_win", 32'(lat >= 11 && lat <= 14), 1);
        chk("rise_clean0", 32'(sw_clean[0]), 1);
        for (int k = 0; k < 4; k++) step(1'b0, 10'h001);
        chk("rise_pulses", 32'(pulses[0]), 1);
        chk("rise_others", 32'(sw_clean[W-1:1]), 0);

        clr_pulses();
        for (int t = 0; t < 60; t++) step(1'b0, ((t / 5) % 2 == 0) ? 10'h009 : 10'h001);
        chk("bounce_nopulse", 32'(pulses[3]), 0);
        wait_chg(3, 10'h009, 20, lat);
        chk("bounce_lat_win", 32'(lat >= 11 && lat <= 14), 1);
        for (int k = 0; k < 4; k++) step(1'b0, 10'h009);
        chk("bounce_pulses", 32'(pulses[3]), 1);

        clr_pulses();
        for (int k = 0; k < 7; k++) step(1'b0, 10'h209);
        for (int k = 0; k < 20; k++) step(1'b0, 10'h009);
        chk("glitch_clean9", 32'(sw_clean[9]), 0);
        begin
            int s = 0;
            for (int i = 0; i < W; i++) s += pulses[i];
            chk("glitch_nochg", 32'(s), 0);
        end

        for (int k = 0; k < 2; k++) step(1'b1, '0);
        for (int k = 0; k < 6; k++) step(1'b0, '0);
        chk("simul_pre", 32'(sw_clean), 0);
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            step(1'b0, 10'h3FF);
            if (sw_changed != '0) lat = k + 1;
        end
        chk("simul_chg", 32'(sw_changed), 32'h3FF);
        chk("simul_clean", 32'(sw_clean), 32'h3FF);

        clr_pulses();
        wait_chg(2, 10'h3FB, 20, lat);
        chk("fall_lat_win", 32'(lat >= 11 && lat <= 14), 1);
        for (int k = 0; k < 4; k++) step(1'b0, 10'h3FB);
        chk("fall_pulses", 32'(pulses[2]), 1);
        chk("fall_clean", 32'(sw_clean), 32'h3FB);

        for (int k = 0; k < 2; k++) step(1'b1, '0);
        for (int k = 0; k < 5; k++) step(1'b0, '0);
        begin
            int n = 0;
            while (m_ticks[5] != 2 && n < 20) begin
                step(1'b0, 10'h020);
                n++;
            end
            chk("midrst_reach", 32'(m_ticks[5]), 2);
        end
        step(1'b1, 10'h020);
        chk("midrst_clean", 32'(sw_clean), 0);
        chk("midrst_chg", 32'(sw_changed), 0);
        wait_chg(5, 10'h020, 20, lat);
        chk("midrst_lat_win", 32'(lat >= 11 && lat <= 14), 1);
        chk("midrst_clean5", 32'(sw_clean), 32'h020);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
